// File: rtl/parity_engine.sv
// parity_engine
//   Parity generator/checker over a runtime-selectable data length
//   (1..MAX_DATA_WIDTH bits). It supports five modes: none, even, odd, mark
//   and space. In check mode it compares a received parity bit against the
//   computed one. It keeps a sticky error flag and a saturating error counter.
//   The UART TX path uses it to generate parity and the UART RX path uses it
//   to check parity.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset, highest priority
//   data_in      data word, LSB-aligned
//   data_len     number of valid LSBs; 0 or > MAX_DATA_WIDTH means full width
//   data_valid   1-cycle strobe that samples all per-word inputs
//   parity_mode  000 none, 001 even, 010 odd, 011 mark, 100 space, others none
//   chk_en       1 = compare rx_parity against the computed parity
//   rx_parity    received parity bit
//   err_clr      clears err_count and sticky_err
//   parity_bit   computed parity of the last sampled word (held between strobes)
//   parity_valid 1-cycle pulse, one cycle after each strobe
//   parity_err   1-cycle pulse with parity_valid when a check mismatches
//   sticky_err   set by any parity_err, held until err_clr or rst
//   err_count    saturating count of parity_err pulses

module parity_engine #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MAX_DATA_WIDTH-1:0] data_in,
  input  logic [3:0]                data_len,
  input  logic                      data_valid,
  input  logic [2:0]                parity_mode,
  input  logic                      chk_en,
  input  logic                      rx_parity,
  input  logic                      err_clr,
  output logic                      parity_bit,
  output logic                      parity_valid,
  output logic                      parity_err,
  output logic                      sticky_err,
  output logic [CNT_WIDTH-1:0]      err_count
);

  localparam logic [2:0] MODE_EVEN  = 3'b001;
  localparam logic [2:0] MODE_ODD   = 3'b010;
  localparam logic [2:0] MODE_MARK  = 3'b011;
  localparam logic [2:0] MODE_SPACE = 3'b100;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  int   eff_len;
  logic x_sum;
  logic par_next;
  logic mode_active;
  logic err_next;

  always_comb begin
    eff_len = int'(data_len);
    if (data_len == 4'd0 || int'(data_len) > MAX_DATA_WIDTH)
      eff_len = MAX_DATA_WIDTH;

    x_sum = 1'b0;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (i < eff_len)
        x_sum = x_sum ^ data_in[i];
    end

    par_next    = 1'b0;
    mode_active = 1'b1;
    case (parity_mode)
      MODE_EVEN:  par_next = x_sum;
      MODE_ODD:   par_next = ~x_sum;
      MODE_MARK:  par_next = 1'b1;
      MODE_SPACE: par_next = 1'b0;
      default:    mode_active = 1'b0;  // none and reserved codes
    endcase

    err_next = data_valid & chk_en & mode_active & (rx_parity != par_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bit   <= 1'b0;
      parity_valid <= 1'b0;
      parity_err   <= 1'b0;
      sticky_err   <= 1'b0;
      err_count    <= '0;
    end else begin
      parity_valid <= data_valid;
      parity_err   <= err_next;
      if (data_valid)
        parity_bit <= par_next;

      // A new error wins over a simultaneous clear.
      if (err_next)
        sticky_err <= 1'b1;
      else if (err_clr)
        sticky_err <= 1'b0;

      // A clear and an error in the same cycle clear first, then count, so the result is 1.
      if (err_clr)
        err_count <= err_next ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : '0;
      else if (err_next && err_count != CNT_MAX)
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_engine.sv
module tb_parity_engine;

  localparam int W  = 9;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in;
  logic [3:0]    data_len;
  logic          data_valid;
  logic [2:0]    parity_mode;
  logic          chk_en;
  logic          rx_parity;
  logic          err_clr;
  logic          parity_bit;
  logic          parity_valid;
  logic          parity_err;
  logic          sticky_err;
  logic [CW-1:0] err_count;

  parity_engine #(.MAX_DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_len(data_len),
    .data_valid(data_valid), .parity_mode(parity_mode), .chk_en(chk_en),
    .rx_parity(rx_parity), .err_clr(err_clr), .parity_bit(parity_bit),
    .parity_valid(parity_valid), .parity_err(parity_err),
    .sticky_err(sticky_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic pbit; logic perr; } exp_t;
  exp_t q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_strobes = 0;
  int   n_pulses = 0;
  bit   mon_en = 0;
  logic exp_sticky = 0;
  int   exp_count = 0;
  logic last_pbit = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_parity(input logic [W-1:0] d, input logic [3:0] l, input logic [2:0] m);
    int   n;
    logic x;
    n = (l == 0 || int'(l) > W) ? W : int'(l);
    x = 1'b0;
    for (int i = 0; i < n; i++) x = x ^ d[i];
    case (m)
      3'd1: return x;
      3'd2: return ~x;
      3'd3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic step(input logic r, input logic dv, input logic [W-1:0] d, input logic [3:0] l,
                      input logic [2:0] m, input logic ce, input logic rp, input logic ec);
    logic pb, er;
    rst = r; data_valid = dv; data_in = d; data_len = l;
    parity_mode = m; chk_en = ce; rx_parity = rp; err_clr = ec;
    @(posedge clk);
    #1;
    if (r) begin
      exp_sticky = 0; exp_count = 0; last_pbit = 0;
      q.delete();
    end else begin
      pb = ref_parity(d, l, m);
      er = dv & ce & (m >= 3'd1 && m <= 3'd4) & (rp != pb);
      if (ec) begin
        exp_count  = er ? 1 : 0;
        exp_sticky = er;
      end else if (er) begin
        exp_sticky = 1;
        if (exp_count < (1 << CW) - 1) exp_count++;
      end
      if (dv) begin
        q.push_back('{pbit: pb, perr: er});
        last_pbit = pb;
        n_strobes++;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        n_pulses++;
        check("pvalid", parity_valid, 1);
        check("pbit", parity_bit, e.pbit);
        check("perr", parity_err, e.perr);
      end else begin
        check("pvalid_idle", parity_valid, 0);
        check("perr_idle", parity_err, 0);
        check("pbit_hold", parity_bit, last_pbit);
      end
      check("sticky", sticky_err, exp_sticky);
      check("count", err_count, exp_count);
    end
  end

  // Settle on the next negedge (after the monitor) for directed literal checks.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset held 2 cycles with a strobe present.
    step(1, 1, 9'h0B3, 4'd8, 3'd1, 1, 1, 0);
    mon_en = 1;
    step(1, 1, 9'h0B3, 4'd8, 3'd1, 1, 1, 0);
    step(0, 0, 9'h000, 4'd8, 3'd1, 0, 0, 0);
    settle();
    check("rst_pvalid", parity_valid, 0);
    check("rst_pbit", parity_bit, 0);
    check("rst_count", err_count, 0);
    check("rst_sticky", sticky_err, 0);

    // Modes on 0x0B, len 8 (three ones).
    step(0, 1, 9'h00B, 4'd8, 3'd1, 0, 0, 0); settle(); check("mode_even", parity_bit, 1);
    step(0, 1, 9'h00B, 4'd8, 3'd2, 0, 0, 0); settle(); check("mode_odd", parity_bit, 0);
    step(0, 1, 9'h00B, 4'd8, 3'd3, 0, 0, 0); settle(); check("mode_mark", parity_bit, 1);
    step(0, 1, 9'h00B, 4'd8, 3'd4, 0, 0, 0); settle(); check("mode_space", parity_bit, 0);
    step(0, 1, 9'h00B, 4'd8, 3'd3, 0, 0, 0);
    step(0, 1, 9'h00B, 4'd8, 3'd0, 0, 0, 0); settle(); check("mode_none", parity_bit, 0);
    step(0, 1, 9'h00B, 4'd8, 3'd3, 0, 0, 0);
    step(0, 1, 9'h00B, 4'd8, 3'd6, 1, 1, 0); settle(); check("mode_rsvd", parity_bit, 0);
    check("rsvd_noerr", err_count, 0);
    // Mode/len changes without a strobe leave the held parity alone.
    step(0, 0, 9'h00B, 4'd1, 3'd3, 0, 0, 0); settle(); check("no_strobe", parity_bit, 0);

    // Masking.
    step(0, 1, 9'h1FF, 4'd5, 3'd1, 0, 0, 0); settle(); check("mask_len5", parity_bit, 1);
    step(0, 1, 9'h1FF, 4'd0, 3'd1, 0, 0, 0); settle(); check("mask_len0", parity_bit, 1);
    step(0, 1, 9'h1FF, 4'd4, 3'd1, 0, 0, 0); settle(); check("mask_len4", parity_bit, 0);
    step(0, 1, 9'h0FF, 4'd8, 3'd1, 0, 0, 0); settle(); check("mask_b8_lo", parity_bit, 0);
    step(0, 1, 9'h1FF, 4'd8, 3'd1, 0, 0, 0); settle(); check("mask_b8_hi", parity_bit, 0);
    step(0, 1, 9'h1FF, 4'd12, 3'd1, 0, 0, 0); settle(); check("mask_len12", parity_bit, 1);

    // Check mode.
    step(0, 1, 9'h003, 4'd8, 3'd1, 1, 1, 0); settle();
    check("chk_err", parity_err, 1); check("chk_sticky", sticky_err, 1); check("chk_cnt", err_count, 1);
    step(0, 1, 9'h003, 4'd8, 3'd1, 1, 0, 0); settle(); check("chk_ok", parity_err, 0);
    step(0, 1, 9'h003, 4'd8, 3'd1, 0, 1, 0); settle(); check("chk_dis", parity_err, 0);
    check("chk_cnt_hold", err_count, 1);

    // Saturation with 20 back-to-back errors, then clear interactions.
    for (int i = 0; i < 20; i++) step(0, 1, 9'h003, 4'd8, 3'd1, 1, 1, 0);
    settle(); check("sat_cnt", err_count, 15);
    step(0, 1, 9'h003, 4'd8, 3'd1, 1, 1, 1); settle();
    check("clr_err_cnt", err_count, 1); check("clr_err_sticky", sticky_err, 1);
    step(0, 0, 9'h003, 4'd8, 3'd1, 1, 1, 1); settle();
    check("clr_cnt", err_count, 0); check("clr_sticky", sticky_err, 0);

    // Mid-operation reset discards the strobe of that cycle.
    step(0, 1, 9'h003, 4'd8, 3'd1, 1, 1, 0);
    step(1, 1, 9'h001, 4'd8, 3'd1, 1, 0, 0);
    step(0, 0, 9'h000, 4'd8, 3'd1, 0, 0, 0);
    settle(); check("midrst_pvalid", parity_valid, 0); check("midrst_cnt", err_count, 0);

    // Random traffic against the model.
    n_strobes = 0; n_pulses = 0;
    for (int i = 0; i < 10000; i++)
      step(0, 1'($urandom_range(0, 9) != 0), 9'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 1'($urandom_range(0, 49) == 0));
    step(0, 0, 9'h000, 4'd8, 3'd0, 0, 0, 0);
    settle();
    check("pulse_count", n_pulses, n_strobes);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
